// File: rtl/traffic_pkg.sv
// Shared types and constants for the timed two-road traffic signal:
// phase encoding, ASCII lamp codes and the phase-to-lamp decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN      = 3'd0,
    MAIN_YELLOW     = 3'd1,
    CLEAR_TO_COUNTY = 3'd2,
    COUNTY_GREEN    = 3'd3,
    COUNTY_YELLOW   = 3'd4,
    CLEAR_TO_MAIN   = 3'd5
  } phase_t;

  localparam logic [7:0] LAMP_GREEN  = 8'h47;
  localparam logic [7:0] LAMP_YELLOW = 8'h59;
  localparam logic [7:0] LAMP_RED    = 8'h52;

  typedef struct packed {
    logic [7:0] main_lamp;
    logic [7:0] county_lamp;
  } lamps_t;

  // Anything outside the six legal codes shows red on both roads.
  function automatic lamps_t decode_lamps(input logic [2:0] ph);
    lamps_t l;
    l.main_lamp   = LAMP_RED;
    l.county_lamp = LAMP_RED;
    case (ph)
      MAIN_GREEN:    l.main_lamp   = LAMP_GREEN;
      MAIN_YELLOW:   l.main_lamp   = LAMP_YELLOW;
      COUNTY_GREEN:  l.county_lamp = LAMP_GREEN;
      COUNTY_YELLOW: l.county_lamp = LAMP_YELLOW;
      default:       ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; expired flags the zero count.
module phase_timer #(
  parameter int               CNT_W     = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/traffic_signal_timed.sv
// Two-road traffic signal with dwell timers, all-red clearance and a
// synchronised county-road sensor; lamp outputs are Moore-decoded.
module traffic_signal_timed
  import traffic_pkg::*;
#(
  parameter int CNT_W            = 8,
  parameter int MAIN_MIN_GREEN   = 8,
  parameter int COUNTY_MAX_GREEN = 10,
  parameter int YELLOW_TIME      = 3,
  parameter int ALL_RED_TIME     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [7:0] main_road,
  output logic [7:0] county_road,
  output logic [2:0] phase
);

  localparam longint TIME_LIMIT = longint'(1) << CNT_W;

  if (MAIN_MIN_GREEN < 1 || longint'(MAIN_MIN_GREEN) > TIME_LIMIT ||
      COUNTY_MAX_GREEN < 1 || longint'(COUNTY_MAX_GREEN) > TIME_LIMIT ||
      YELLOW_TIME < 1 || longint'(YELLOW_TIME) > TIME_LIMIT ||
      ALL_RED_TIME < 1 || longint'(ALL_RED_TIME) > TIME_LIMIT) begin : g_bad_time
    $error("traffic_signal_timed: every *_TIME must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_MAIN   = CNT_W'(MAIN_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_COUNTY = CNT_W'(COUNTY_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(ALL_RED_TIME - 1);

  logic             x_meta;
  logic             x_s;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             expired;
  lamps_t           lamps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_meta  <= 1'b0;
      x_s     <= 1'b0;
      state_q <= MAIN_GREEN;
    end else begin
      x_meta  <= x;
      x_s     <= x_meta;
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    load_val = LD_MAIN;
    case (state_q)
      MAIN_GREEN:      if (expired && x_s) state_d = MAIN_YELLOW;
      MAIN_YELLOW:     if (expired)        state_d = CLEAR_TO_COUNTY;
      CLEAR_TO_COUNTY: if (expired)        state_d = COUNTY_GREEN;
      COUNTY_GREEN:    if (!x_s || expired) state_d = COUNTY_YELLOW;
      COUNTY_YELLOW:   if (expired)        state_d = CLEAR_TO_MAIN;
      CLEAR_TO_MAIN:   if (expired)        state_d = MAIN_GREEN;
      default:                             state_d = MAIN_GREEN;
    endcase

    case (state_d)
      MAIN_YELLOW, COUNTY_YELLOW:       load_val = LD_YELLOW;
      CLEAR_TO_COUNTY, CLEAR_TO_MAIN:   load_val = LD_RED;
      COUNTY_GREEN:                     load_val = LD_COUNTY;
      default:                          load_val = LD_MAIN;
    endcase
  end

  // Reload on every state change, including recovery from an illegal code.
  assign load = (state_d != state_q);

  phase_timer #(
    .CNT_W    (CNT_W),
    .RESET_VAL(LD_MAIN)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .expired (expired)
  );

  assign lamps       = decode_lamps(state_q);
  assign main_road   = lamps.main_lamp;
  assign county_road = lamps.county_lamp;
  assign phase       = state_q;

endmodule
